// File: rtl/symbol_seq_tx.sv
// Frame transmitter for the two-bit symbol interface: clears the downstream
// detector, plays out up to MAX_SYM symbols, then captures the detector's o1.
module symbol_seq_tx #(
  parameter int MAX_SYM = 8,
  parameter int DIV_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [2*MAX_SYM-1:0]   load_syms,
  input  logic [3:0]             load_len,
  input  logic [DIV_W-1:0]       load_div,
  output logic                   det_rst,
  output logic                   i1,
  output logic                   i2,
  input  logic                   o1,
  output logic                   busy,
  output logic                   done,
  output logic                   result
);

  localparam int IDX_W = $clog2(MAX_SYM) + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SEND, SETTLE, DONE} state_t;

  state_t               state;
  logic [2*MAX_SYM-1:0] syms_sh;
  logic [2*MAX_SYM-1:0] syms_next;
  logic [IDX_W-1:0]     len_q;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     len_clamped;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     hold;
  logic                 phase;

  always_comb begin
    len_clamped = IDX_W'(MAX_SYM);
    if (int'(load_len) <= MAX_SYM) len_clamped = IDX_W'(load_len);
  end

  // The current symbol always sits in the low two bits of the shift register.
  assign syms_next  = syms_sh >> 2;
  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      det_rst <= 1'b1;
      i1      <= 1'b0;
      i2      <= 1'b0;
      done    <= 1'b0;
      result  <= 1'b0;
      syms_sh <= '0;
      len_q   <= '0;
      div_q   <= '0;
      idx     <= '0;
      hold    <= '0;
      phase   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          det_rst <= 1'b0;
          {i1, i2} <= 2'b00;
          done    <= 1'b0;
          if (load_valid) begin
            syms_sh <= load_syms;
            len_q   <= len_clamped;
            div_q   <= load_div;
            phase   <= 1'b0;
            det_rst <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase   <= 1'b0;
            det_rst <= 1'b0;
            hold    <= '0;
            idx     <= '0;
            if (len_q == '0) begin
              state <= SETTLE;
            end else begin
              {i1, i2} <= syms_sh[1:0];
              state    <= SEND;
            end
          end
        end
        SEND: begin
          if (hold == div_q) begin
            hold <= '0;
            if (idx == len_q - IDX_W'(1)) begin
              {i1, i2} <= 2'b00;
              state    <= SETTLE;
            end else begin
              idx      <= idx + IDX_W'(1);
              syms_sh  <= syms_next;
              {i1, i2} <= syms_next[1:0];
            end
          end else begin
            hold <= hold + DIV_W'(1);
          end
        end
        SETTLE: begin
          // o1 is sampled on the edge closing the second settle cycle.
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase  <= 1'b0;
            result <= o1;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_symbol_seq_tx.sv
// Directed bench for symbol_seq_tx: table-driven frames plus hand-written
// back-to-back and mid-frame reset sequences.
module tb_symbol_seq_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_syms;
  logic [3:0]  load_len;
  logic [7:0]  load_div;
  logic        det_rst;
  logic        i1;
  logic        i2;
  logic        o1;
  logic        busy;
  logic        done;
  logic        result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  len;
    logic [7:0]  div;
    logic [15:0] syms;
    logic        o1_def;
    int          o1_low_cyc;
    int          busy_pulse_cyc;
    int          exp_nsym;
    int          exp_done_cyc;
    logic        exp_result;
  } vec_t;

  vec_t vecs [4];

  symbol_seq_tx #(.MAX_SYM(8), .DIV_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_syms  (load_syms),
    .load_len   (load_len),
    .load_div   (load_div),
    .det_rst    (det_rst),
    .i1         (i1),
    .i2         (i2),
    .o1         (o1),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] sampled();
    return {det_rst, i1, i2, busy, done, load_ready};
  endfunction

  // Expected {det_rst, i1, i2, busy, done, load_ready} at cycle c of a frame.
  function automatic logic [5:0] expTrace(int c, int done_c, int nsym, int div,
                                          logic [15:0] syms);
    logic       dr, bz, dn;
    logic [1:0] sym;
    int         k;
    dr  = (c >= 1 && c <= 2);
    bz  = (c >= 1 && c <= done_c);
    dn  = (c == done_c);
    sym = 2'b00;
    if (c >= 3) begin
      k = (c - 3) / (div + 1);
      if (k < nsym) sym = syms[2*k +: 2];
    end
    return {dr, sym, bz, dn, !bz};
  endfunction

  task automatic checkOutput(input string name, input int cyc,
                             input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] len, input logic [7:0] div,
                               input logic [15:0] syms, input logic o1v);
    load_len   = len;
    load_div   = div;
    load_syms  = syms;
    o1         = o1v;
    load_valid = 1'b1;
  endtask

  task automatic runFrame(input vec_t v, input string name);
    int n = 0;
    while (!load_ready && n < 100) begin
      tick();
      n++;
    end
    checkOutput({name, " ready_wait"}, 0, {5'b0, load_ready}, 6'b000001);
    applyStimulus(v.len, v.div, v.syms, v.o1_def);
    checkOutput(name, 0, sampled(),
                expTrace(0, v.exp_done_cyc, v.exp_nsym, int'(v.div), v.syms));
    for (int c = 1; c <= v.exp_done_cyc + 1; c++) begin
      tick();
      load_valid = (c == v.busy_pulse_cyc);
      o1 = (c == v.o1_low_cyc) ? !v.o1_def : v.o1_def;
      checkOutput(name, c, sampled(),
                  expTrace(c, v.exp_done_cyc, v.exp_nsym, int'(v.div), v.syms));
      if (c == v.exp_done_cyc)
        checkOutput({name, " result"}, c, {5'b0, result}, {5'b0, v.exp_result});
    end
    load_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] exp;

    vecs[0] = '{len: 4'd2,  div: 8'd0, syms: 16'h0002, o1_def: 1'b1, o1_low_cyc: -1,
                busy_pulse_cyc: -1, exp_nsym: 2, exp_done_cyc: 7,  exp_result: 1'b1};
    vecs[1] = '{len: 4'd3,  div: 8'd2, syms: 16'h002D, o1_def: 1'b1, o1_low_cyc: 13,
                busy_pulse_cyc: -1, exp_nsym: 3, exp_done_cyc: 14, exp_result: 1'b0};
    vecs[2] = '{len: 4'd0,  div: 8'd5, syms: 16'hFFFF, o1_def: 1'b1, o1_low_cyc: -1,
                busy_pulse_cyc: -1, exp_nsym: 0, exp_done_cyc: 5,  exp_result: 1'b1};
    vecs[3] = '{len: 4'd12, div: 8'd0, syms: 16'h9C63, o1_def: 1'b0, o1_low_cyc: -1,
                busy_pulse_cyc: 5,  exp_nsym: 8, exp_done_cyc: 13, exp_result: 1'b0};

    rst        = 1'b1;
    load_valid = 1'b0;
    load_syms  = '0;
    load_len   = '0;
    load_div   = '0;
    o1         = 1'b0;
    repeat (3) tick();
    checkOutput("reset_state", 0, sampled(), 6'b100001);
    checkOutput("reset_result", 0, {5'b0, result}, 6'b000000);
    rst = 1'b0;
    tick();
    checkOutput("post_reset", 1, sampled(), 6'b000001);

    for (int i = 0; i < 4; i++) begin
      $display("[TB] frame vector %0d", i);
      runFrame(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back frames with load_valid held high: accepts at 0 and 7.
    $display("[TB] back-to-back frames");
    applyStimulus(4'd1, 8'd0, 16'h0003, 1'b1);
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) tick();
      exp[5]   = (c == 1 || c == 2 || c == 8 || c == 9);
      exp[4:3] = (c == 3 || c == 10) ? 2'b11 : 2'b00;
      exp[2]   = (c >= 1 && c <= 6) || (c >= 8 && c <= 13);
      exp[1]   = (c == 6 || c == 13);
      exp[0]   = !exp[2];
      checkOutput("b2b", c, sampled(), exp);
    end
    load_valid = 1'b0;
    checkOutput("b2b result", 14, {5'b0, result}, 6'b000001);

    // Reset during cycle 4 of an L=4, D=1 frame.
    $display("[TB] mid-frame reset");
    tick();
    applyStimulus(4'd4, 8'd1, 16'h001E, 1'b1);
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) begin
        tick();
        load_valid = 1'b0;
      end
      checkOutput("midrst", c, sampled(), expTrace(c, 13, 4, 1, 16'h001E));
    end
    rst = 1'b1;
    tick();
    checkOutput("midrst in_reset", 5, sampled(), 6'b100001);
    checkOutput("midrst result", 5, {5'b0, result}, 6'b000000);
    rst = 1'b0;
    tick();
    checkOutput("midrst released", 6, sampled(), 6'b000001);
    runFrame(vecs[0], "fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/symbol_seq_tx.md
# symbol_seq_tx

Transmit side of the two-bit symbol interface (`i1`, `i2`) used by the team's sequence-detector FSMs. The block accepts a frame of up to `MAX_SYM` two-bit symbols and a hold count. It clears the downstream detector with a reset pulse, then drives the symbols one per symbol period. After a fixed settle window it captures the detector's `o1` response into `result`. It replaces hand-timed testbench stimulus and serves as the on-chip driver for detector instances.

## Interface
- `MAX_SYM`, default 8: maximum symbols per frame.
- `DIV_W`, default 8: width of the symbol hold count.

- `clk` input 1: rising-edge clock; the only clock.
- `rst` input 1: reset, synchronous and active-high.
- `load_valid` input 1: frame offer.
- `load_ready` output 1: high only in IDLE; a frame is accepted on a cycle where `load_valid` and `load_ready` are both high.
- `load_syms` input 2*MAX_SYM: symbol k is `load_syms[2k+1:2k]`; bit 1 drives `i1`, bit 0 drives `i2`.
- `load_len` input 4: number of symbols, 0..15. Values above `MAX_SYM` clamp to `MAX_SYM`.
- `load_div` input DIV_W: each symbol is held for `load_div`+1 cycles.
- `det_rst` output 1: reset to the downstream detector.
- `i1`, `i2` output 1 each: symbol lines; 00 whenever no symbol is being sent.
- `o1` input 1: detector response.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when `result` is updated.
- `result` output 1: the captured `o1`; holds its value until the next capture.

## Operation
- All outputs are registered except `load_ready` and `busy`, which decode the state register.
- The state machine has five states: IDLE, CLEAR, SEND, SETTLE, DONE.
- IDLE:
  - `i1`=`i2`=0 and `det_rst`=0.
  - On accept, latch `load_syms`, the clamped `load_len` (L) and `load_div` (D), then go to CLEAR.
  - A new frame cannot be accepted while `busy`=1; `load_valid` is ignored.
- CLEAR:
  - `det_rst`=1 and `i1`=`i2`=0 for exactly 2 cycles.
  - Then go to SEND, or straight to SETTLE if L=0.
- SEND:
  - Drive symbol k for D+1 cycles, for k = 0..L-1 in ascending order.
  - Use an internal hold counter of DIV_W bits and a symbol index of clog2(MAX_SYM)+1 bits. Both counters count up, and neither wraps within a frame.
  - After symbol L-1 completes its hold, go to SETTLE.
- SETTLE:
  - `i1`=`i2`=0 for exactly 2 cycles.
  - On the clock edge that ends the second settle cycle, `result` takes the value of `o1`.
- DONE:
  - `done`=1 and `i1`=`i2`=0 for 1 cycle, then go to IDLE.
- `rst` asserted in any state, including mid-frame:
  - Next cycle the block is in IDLE and all registered outputs are at their reset values.
  - The latched frame is discarded and `done` is not pulsed.
- Reset values: `det_rst`=1, `i1`=0, `i2`=0, `done`=0, `result`=0. In the first cycle after `rst` deasserts, `det_rst`=0, `load_ready`=1 and `busy`=0.

## Timing
Cycle numbering: the accept cycle is cycle 0.
- Cycles 1–2: `det_rst`=1 and `busy`=1.
- Cycles 3+k(D+1) through 2+(k+1)(D+1): symbol k on `i1`/`i2`.
- Cycles 3+L(D+1) and 4+L(D+1): settle, with `i1`/`i2`=00.
- Cycle 5+L(D+1): `done`=1, and `result` shows the `o1` value sampled at the end of cycle 4+L(D+1).
- Cycle 6+L(D+1): IDLE, `load_ready`=1, earliest next accept.
- Frame length is 6+L(D+1) cycles, accept cycle to accept cycle. Maximum is 6 + MAX_SYM·2^DIV_W.
- Symbol transitions happen only on clock edges; there are no glitches on `i1`/`i2` (registered outputs).

## Test plan
- L=2, syms = {k0=10, k1=00}, D=0; bench holds `o1`=1:
  - `det_rst` is high in cycles 1–2, `i1i2`=10 in cycle 3 and 00 in cycle 4.
  - `done` pulses in cycle 7 with `result`=1.
  - `load_ready` returns in cycle 8.
- L=3, syms = {01, 11, 10}, D=2:
  - Each symbol is held 3 cycles: cycles 3–5, 6–8 and 9–11.
  - Settle is cycles 12–13 and `done` pulses in cycle 14.
  - With `o1` driven 0 in cycle 13 only, `result`=0.
- L=0, any D:
  - CLEAR runs in cycles 1–2 and settle in cycles 3–4.
  - `done` pulses in cycle 5 and no non-zero symbol is ever driven.
- `load_len`=12 with MAX_SYM=8, D=0:
  - Exactly 8 symbols are sent and `done` pulses in cycle 13.
  - A `load_valid` pulse during `busy` is ignored and produces no extra frame.
- `rst` asserted in cycle 4 of a frame with L=4, D=1:
  - In cycle 5, `det_rst`=1, `i1i2`=00, `busy`=0 and `done`=0.
  - After `rst` deasserts, `load_ready`=1 and a fresh frame runs normally.
- Back-to-back frames, with `load_valid` held high and L=1, D=0:
  - Accepts occur in cycles 0 and 7.
  - There is exactly one `done` per frame, in cycles 6 and 13.
